// File: rtl/jpeg2bmp_mul_acc_pipe.sv
// ---------------------------------------------------------------------------
// jpeg2bmp_mul_acc_pipe
//
// Pipelined signed multiply / multiply-accumulate unit for the jpeg2bmp
// datapath (IDCT butterflies, dequantisation, colour conversion).
//
// Pipeline, for a sample accepted at edge k:
//   stage 1          : operand and tag registers               (edge k)
//   product stages   : NUM_STAGE-1 registers carrying din0*din1 (edges k+1 ..)
//   output register  : sum, round, shift, saturate             (edge k+NUM_STAGE)
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   synchronous active-low reset
//   ce         clock enable, 0 freezes every register including the accumulator
//   in_valid   input sample valid
//   in_ready   sample can be accepted (low while stalled or in reset)
//   din0/din1  signed operands
//   in_acc     1 = add product to running sum, 0 = standalone product
//   in_last    with in_acc=1, marks the final term of a sum
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   dout       signed result
//   out_sat    result was clamped (never set when SATURATE=0)
// ---------------------------------------------------------------------------
module jpeg2bmp_mul_acc_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0,
    parameter int SATURATE   = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         in_acc,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_sat
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int RW = ACC_WIDTH + 1;
    localparam int NP = NUM_STAGE - 1;

    // Half-LSB rounding constant; zero when no shift is applied, so the
    // same add-then-shift path serves both cases.
    localparam logic signed [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

    localparam logic signed [RW-1:0] RMAX =
        {{(RW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] RMIN =
        {{(RW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
    localparam logic signed [DOUT_WIDTH-1:0] DMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] DMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    logic                         stall;
    logic                         advance;

    logic                         s1_valid;
    logic                         s1_acc;
    logic                         s1_last;
    logic signed [DIN0_WIDTH-1:0] s1_din0;
    logic signed [DIN1_WIDTH-1:0] s1_din1;
    logic signed [PW-1:0]         s1_a_ext;
    logic signed [PW-1:0]         s1_b_ext;

    logic signed [PW-1:0]         prod_q [NP];
    logic [NP-1:0]                pv_q;
    logic [NP-1:0]                pacc_q;
    logic [NP-1:0]                plast_q;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [RW-1:0]         sum_wide;
    logic signed [RW-1:0]         rounded;
    logic signed [DOUT_WIDTH-1:0] res;
    logic                         res_sat;
    logic                         produce;

    // The whole pipeline stalls as one unit: a held result blocks every
    // stage behind it, so no per-stage skid logic is needed.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ap_rst_n;
    assign advance  = ce & ~stall;

    // Operands are widened to the full product width before multiplying so
    // the multiply is evaluated at PW bits rather than the operand width.
    always_comb begin
        s1_a_ext = PW'(s1_din0);
        s1_b_ext = PW'(s1_din1);
    end

    // Final stage arithmetic. The rounding add happens one bit wider than
    // the accumulator so it cannot wrap; saturation then compares the
    // shifted value against the signed output range.
    always_comb begin
        prod_ext = ACC_WIDTH'(prod_q[NP-1]);
        sum      = pacc_q[NP-1] ? (acc + prod_ext) : prod_ext;
        sum_wide = RW'(sum);
        rounded  = (sum_wide + RND) >>> SHIFT;
        produce  = pv_q[NP-1] & (~pacc_q[NP-1] | plast_q[NP-1]);
        res      = rounded[DOUT_WIDTH-1:0];
        res_sat  = 1'b0;
        if (SATURATE != 0) begin
            if (rounded > RMAX) begin
                res     = DMAX;
                res_sat = 1'b1;
            end else if (rounded < RMIN) begin
                res     = DMIN;
                res_sat = 1'b1;
            end
        end
    end

    // All state advances together. Bubbles shift through like samples but
    // never touch the accumulator; a standalone product leaves a sum in
    // progress intact. The output register only reloads when a result is
    // produced, so dout holds its last value once out_valid drops.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_valid  <= 1'b0;
            s1_acc    <= 1'b0;
            s1_last   <= 1'b0;
            s1_din0   <= '0;
            s1_din1   <= '0;
            for (int i = 0; i < NP; i++) begin
                prod_q[i] <= '0;
            end
            pv_q      <= '0;
            pacc_q    <= '0;
            plast_q   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            dout      <= '0;
        end else if (advance) begin
            s1_valid   <= in_valid;
            s1_acc     <= in_acc;
            s1_last    <= in_last;
            s1_din0    <= din0;
            s1_din1    <= din1;
            prod_q[0]  <= s1_a_ext * s1_b_ext;
            pv_q[0]    <= s1_valid;
            pacc_q[0]  <= s1_acc;
            plast_q[0] <= s1_last;
            for (int i = 1; i < NP; i++) begin
                prod_q[i]  <= prod_q[i-1];
                pv_q[i]    <= pv_q[i-1];
                pacc_q[i]  <= pacc_q[i-1];
                plast_q[i] <= plast_q[i-1];
            end
            if (pv_q[NP-1] && pacc_q[NP-1]) begin
                acc <= plast_q[NP-1] ? '0 : sum;
            end
            out_valid <= produce;
            if (produce) begin
                dout    <= res;
                out_sat <= res_sat;
            end
        end
    end

endmodule

// File: tb/tb_jpeg2bmp_mul_acc_pipe.sv
// ---------------------------------------------------------------------------
// tb_jpeg2bmp_mul_acc_pipe
//
// Three instances share one input stream:
//   dut 0 : defaults (SHIFT=0, SATURATE=1)
//   dut 1 : SHIFT=2, SATURATE=1
//   dut 2 : SHIFT=0, SATURATE=0
// A reference model records the exact sum S of every result in acceptance
// order; each instance's expected dout/out_sat is derived from S with plain
// 64-bit arithmetic for that instance's shift/saturation setting.
// ---------------------------------------------------------------------------
module tb_jpeg2bmp_mul_acc_pipe;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ce;
    logic        in_valid;
    logic [15:0] din0;
    logic [15:0] din1;
    logic        in_acc;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic [15:0] dout_w      [3];
    logic        out_sat_w   [3];

    int          checks   = 0;
    int          failures = 0;

    longint      sq [$];
    int          rd [3];
    longint      macc;
    int          consumed;
    logic [15:0] ed;
    logic        es;
    longint      prod;
    bit          stream_done;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jpeg2bmp_mul_acc_pipe #(
            .SHIFT    (g == 1 ? 2 : 0),
            .SATURATE (g == 2 ? 0 : 1)
        ) u_dut (
            .ap_clk    (ap_clk),
            .ap_rst_n  (ap_rst_n),
            .ce        (ce),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .din0      (din0),
            .din1      (din1),
            .in_acc    (in_acc),
            .in_last   (in_last),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .dout      (dout_w[g]),
            .out_sat   (out_sat_w[g])
        );
    end

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Hard stop in case some wait never resolves.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic longint wrap40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    // Result rule: optional round-half-up shift, then clamp or truncate.
    function automatic void expect_result(input longint s, input int idx,
                                          output logic [15:0] d, output logic sat);
        int     sh;
        bit     clamp;
        longint r;
        sh    = (idx == 1) ? 2 : 0;
        clamp = (idx != 2);
        r     = (sh > 0) ? ((s + (longint'(1) <<< (sh - 1))) >>> sh) : s;
        if (clamp && r > 32767) begin
            d = 16'h7fff; sat = 1'b1;
        end else if (clamp && r < -32768) begin
            d = 16'h8000; sat = 1'b1;
        end else begin
            d = r[15:0]; sat = 1'b0;
        end
    endfunction

    function automatic logic [15:0] rand_op();
        if ($urandom_range(0, 1) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 40)) - 16'd20;
    endfunction

    // Monitor, evaluated mid-cycle where every signal is settled for the
    // coming rising edge: compare held results against the model, retire a
    // result when it is consumed, and record accepted samples.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            sq.delete();
            for (int i = 0; i < 3; i++) rd[i] = 0;
            macc = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid_w[i]) begin
                    checkOutput($sformatf("pending%0d", i), 32'(rd[i] < sq.size()), 32'd1);
                    if (rd[i] < sq.size()) begin
                        expect_result(sq[rd[i]], i, ed, es);
                        checkOutput($sformatf("dout%0d", i), 32'(dout_w[i]), 32'(ed));
                        checkOutput($sformatf("sat%0d", i), 32'(out_sat_w[i]), 32'(es));
                        if (out_ready && ce) begin
                            rd[i]++;
                            if (i == 0) consumed++;
                        end
                    end
                end
            end
            if (in_valid && in_ready_w[0] && ce) begin
                prod = longint'($signed(din0)) * longint'($signed(din1));
                if (!in_acc) begin
                    sq.push_back(prod);
                end else begin
                    macc = wrap40(macc + prod);
                    if (in_last) begin
                        sq.push_back(macc);
                        macc = 0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic acc, input logic last);
        bit ok;
        int n;
        din0 = a; din1 = b; in_acc = acc; in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge ap_clk);
            ok = in_ready_w[0] && ce && ap_rst_n;
            @(posedge ap_clk); #1;
            n++;
        end
        checkOutput("accepted", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic waitValid(input int idx);
        int n;
        n = 0;
        while (!out_valid_w[idx] && n < 30) begin
            @(posedge ap_clk); #1;
            n++;
        end
        checkOutput("valid_wait", 32'(out_valid_w[idx]), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd[0] != sq.size() || rd[1] != sq.size() || rd[2] != sq.size()) && n < 200) begin
            @(posedge ap_clk); #1;
            n++;
        end
        for (int i = 0; i < 3; i++) checkOutput($sformatf("drain%0d", i), 32'(rd[i]), 32'(sq.size()));
    endtask

    initial begin
        int base;
        ap_rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0;
        in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1; consumed = 0; stream_done = 1'b0;

        repeat (3) @(posedge ap_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_valid", 32'(out_valid_w[i]), 32'd0);
            checkOutput("rst_dout",  32'(dout_w[i]),      32'd0);
            checkOutput("rst_sat",   32'(out_sat_w[i]),   32'd0);
            checkOutput("rst_ready", 32'(in_ready_w[i]),  32'd0);
        end
        ap_rst_n = 1'b1;
        #1;
        checkOutput("ready_after_rst", 32'(in_ready_w[0]), 32'd1);

        $display("[TB] products back-to-back");
        applyStimulus(16'd3, 16'd4, 1'b0, 1'b0);
        applyStimulus(16'hfff9, 16'd5, 1'b0, 1'b0);
        applyStimulus(16'h7fff, 16'h7fff, 1'b0, 1'b0);
        checkOutput("lat_early", 32'(out_valid_w[0]), 32'd0);
        @(posedge ap_clk); #1;
        checkOutput("p1_valid", 32'(out_valid_w[0]), 32'd1);
        checkOutput("p1_dout",  32'(dout_w[0]), 32'h000c);
        @(posedge ap_clk); #1;
        checkOutput("p2_dout",  32'(dout_w[0]), 32'hffdd);
        @(posedge ap_clk); #1;
        checkOutput("p3_dout",  32'(dout_w[0]), 32'h7fff);
        checkOutput("p3_sat",   32'(out_sat_w[0]), 32'd1);
        checkOutput("p3_trunc", 32'(dout_w[2]), 32'h0001);
        @(posedge ap_clk); #1;
        checkOutput("p_idle", 32'(out_valid_w[0]), 32'd0);

        $display("[TB] accumulation");
        applyStimulus(16'd2, 16'd3, 1'b1, 1'b0);
        applyStimulus(16'd4, 16'd5, 1'b1, 1'b0);
        applyStimulus(16'hffff, 16'd6, 1'b1, 1'b1);
        checkOutput("acc_quiet0", 32'(out_valid_w[0]), 32'd0);
        @(posedge ap_clk); #1;
        checkOutput("acc_quiet1", 32'(out_valid_w[0]), 32'd0);
        @(posedge ap_clk); #1;
        checkOutput("acc_quiet2", 32'(out_valid_w[0]), 32'd0);
        @(posedge ap_clk); #1;
        checkOutput("acc_valid", 32'(out_valid_w[0]), 32'd1);
        checkOutput("acc_dout",  32'(dout_w[0]), 32'd20);
        checkOutput("acc_shift", 32'(dout_w[1]), 32'd5);

        $display("[TB] rounding");
        applyStimulus(16'd2, 16'd3, 1'b0, 1'b0);
        applyStimulus(16'hfffe, 16'd3, 1'b0, 1'b0);
        repeat (2) @(posedge ap_clk);
        #1;
        checkOutput("rnd_pos", 32'(dout_w[1]), 32'd2);
        @(posedge ap_clk); #1;
        checkOutput("rnd_neg", 32'(dout_w[1]), 32'hffff);

        $display("[TB] negative saturation");
        applyStimulus(16'h8000, 16'h7fff, 1'b0, 1'b0);
        repeat (3) @(posedge ap_clk);
        #1;
        checkOutput("nsat_dout",   32'(dout_w[0]), 32'h8000);
        checkOutput("nsat_sat",    32'(out_sat_w[0]), 32'd1);
        checkOutput("ntrunc_dout", 32'(dout_w[2]), 32'h8000);
        checkOutput("ntrunc_sat",  32'(out_sat_w[2]), 32'd0);

        $display("[TB] backpressure");
        drain();
        base = consumed;
        fork
            begin
                for (int j = 0; j < 8; j++) applyStimulus(rand_op(), rand_op(), 1'b0, 1'b0);
            end
            begin
                waitValid(0);
                out_ready = 1'b0;
                repeat (4) begin
                    @(posedge ap_clk); #1;
                    checkOutput("bp_ready", 32'(in_ready_w[0]), 32'd0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("bp_count", 32'(consumed - base), 32'd8);

        $display("[TB] clock enable");
        fork
            begin
                for (int j = 0; j < 6; j++) applyStimulus(rand_op(), rand_op(), 1'b0, 1'b0);
            end
            begin
                waitValid(0);
                ce = 1'b0;
                repeat (3) begin
                    @(posedge ap_clk); #1;
                    checkOutput("ce_hold", 32'(out_valid_w[0]), 32'd1);
                end
                ce = 1'b1;
            end
        join
        drain();

        $display("[TB] reset mid-sum");
        applyStimulus(16'd3, 16'd3, 1'b1, 1'b0);
        applyStimulus(16'd4, 16'd4, 1'b1, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ready", 32'(in_ready_w[0]), 32'd0);
        @(posedge ap_clk); #1;
        for (int i = 0; i < 3; i++) checkOutput("rst_mid_valid", 32'(out_valid_w[i]), 32'd0);
        ap_rst_n = 1'b1;
        applyStimulus(16'd5, 16'd5, 1'b1, 1'b1);
        repeat (3) @(posedge ap_clk);
        #1;
        checkOutput("rst_sum_valid", 32'(out_valid_w[0]), 32'd1);
        checkOutput("rst_sum_dout",  32'(dout_w[0]), 32'd25);
        checkOutput("rst_sum_shift", 32'(dout_w[1]), 32'd6);

        $display("[TB] random traffic");
        fork
            begin
                for (int j = 0; j < 300; j++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge ap_clk); #1;
                    end
                    applyStimulus(rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                                  ($urandom_range(0, 3) == 0));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge ap_clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    ce        = ($urandom_range(0, 7) != 0);
                end
                out_ready = 1'b1;
                ce        = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
